// File: rtl/tensor_rd_burst_gen_pkg.sv
// Shared types and helpers for the tensor read burst generator.
package tensor_rd_burst_gen_pkg;

  localparam int CMD_ADDR_WIDTH  = 32;
  localparam int CMD_BEATS_WIDTH = 16;
  localparam int CMD_ID_WIDTH    = 4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Live command: addr is the next burst start, beats the count not yet requested.
  typedef struct packed {
    logic [CMD_ADDR_WIDTH-1:0]  addr;
    logic [CMD_BEATS_WIDTH-1:0] beats;
    logic [CMD_ID_WIDTH-1:0]    id;
  } burst_cmd_t;

  // Beats left before the next 4 KB boundary; bytes is a power of two.
  function automatic logic [12:0] beats_to_4k(input logic [11:0] addr, input int unsigned bytes);
    logic [12:0] span;
    span = 13'd4096 - {1'b0, addr};
    return 13'(32'(span) / bytes);
  endfunction

endpackage

// File: rtl/tensor_rd_burst_gen_ctr.sv
// Saturating up/down counter of AR bursts in flight, with a full flag.
module rd_outstanding_ctr #(
  parameter int MAX_COUNT   = 4,
  parameter int COUNT_WIDTH = $clog2(MAX_COUNT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  input  logic                   dec,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && count != COUNT_WIDTH'(MAX_COUNT)) begin
      count <= count + COUNT_WIDTH'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - COUNT_WIDTH'(1);
    end
  end

  assign full = (count >= COUNT_WIDTH'(MAX_COUNT));

endmodule

// File: rtl/tensor_rd_burst_gen.sv
// Splits one tensor-load command into AXI4 INCR read bursts (MAX_BURST cap, no 4 KB
// crossing) and tracks their completion on the R channel.
module tensor_rd_burst_gen
  import tensor_rd_burst_gen_pkg::*;
#(
  parameter int ADDR_WIDTH      = CMD_ADDR_WIDTH,
  parameter int DATA_WIDTH      = 256,
  parameter int ID_WIDTH        = CMD_ID_WIDTH,
  parameter int MAX_BURST       = 256,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BEATS_WIDTH     = CMD_BEATS_WIDTH
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [BEATS_WIDTH-1:0] cmd_beats,
  input  logic [ID_WIDTH-1:0]    cmd_id,
  output logic [ADDR_WIDTH-1:0]  m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  output logic [ID_WIDTH-1:0]    m_axi_arid,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic                   m_axi_rvalid,
  input  logic                   m_axi_rready,
  input  logic                   m_axi_rlast,
  input  logic [1:0]             m_axi_rresp,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output state_t                 dbg_state
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

  // Handshakes: a transfer happens on any cycle where valid and ready are both high;
  // arvalid never drops and araddr/arlen/arid never change until arready is seen.
  state_t                  state, state_nx;
  burst_cmd_t              cmd_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [7:0]              arlen_q;
  logic                    arvalid_q;
  logic                    err_q;
  logic [OW-1:0]           outstanding;
  logic                    full;
  logic                    accept, load, ar_hs, r_last_hs, r_bad;
  logic [ADDR_WIDTH-1:0]   aligned_addr, src_addr;
  logic [BEATS_WIDTH-1:0]  src_rem;
  logic [12:0]             span_beats;
  int unsigned             len_cand;
  logic [8:0]              len;

  assign aligned_addr = cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
  assign accept       = (state == ST_IDLE) && cmd_valid;
  assign ar_hs        = arvalid_q && m_axi_arready;
  assign r_last_hs    = m_axi_rvalid && m_axi_rready && m_axi_rlast;
  assign r_bad        = m_axi_rvalid && m_axi_rready && (m_axi_rresp != 2'b00);

  // Next burst is sized from the fresh command on accept, else from the live command.
  always_comb begin
    src_addr   = accept ? aligned_addr : cmd_q.addr;
    src_rem    = accept ? cmd_beats : cmd_q.beats;
    span_beats = beats_to_4k(src_addr[11:0], BYTES);
    len_cand   = 32'(src_rem);
    if (len_cand > 32'(MAX_BURST)) len_cand = 32'(MAX_BURST);
    if (len_cand > 32'(span_beats)) len_cand = 32'(span_beats);
    len = 9'(len_cand);
  end

  assign load = !full && ((accept && cmd_beats != '0) ||
                          (state == ST_ISSUE && !arvalid_q && cmd_q.beats != '0));

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (cmd_valid) state_nx = (cmd_beats == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (ar_hs && cmd_q.beats == '0) state_nx = ST_DRAIN;
      ST_DRAIN: if (outstanding == '0) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cmd_q <= '{addr: aligned_addr, beats: cmd_beats, id: cmd_id};
        err_q <= 1'b0;
      end else if (busy && r_bad) begin
        err_q <= 1'b1;
      end
      if (load) begin
        araddr_q    <= src_addr;
        arlen_q     <= 8'(len - 9'd1);
        arvalid_q   <= 1'b1;
        cmd_q.addr  <= src_addr + (ADDR_WIDTH'(len) << SIZE);
        cmd_q.beats <= src_rem - BEATS_WIDTH'(len);
      end else if (ar_hs) begin
        arvalid_q <= 1'b0;
      end
    end
  end

  rd_outstanding_ctr #(
    .MAX_COUNT  (MAX_OUTSTANDING),
    .COUNT_WIDTH(OW)
  ) u_outstanding (
    .clk  (aclk),
    .rst  (areset),
    .inc  (ar_hs),
    .dec  (r_last_hs),
    .count(outstanding),
    .full (full)
  );

  assign cmd_ready     = (state == ST_IDLE);
  assign busy          = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done          = (state == ST_DONE);
  assign err           = err_q;
  assign dbg_state     = state;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arid    = cmd_q.id;
  assign m_axi_arvalid = arvalid_q;

endmodule

// File: tb/tb_tensor_rd_burst_gen.sv
// Bench for tensor_rd_burst_gen: three configurations, a randomized AXI read slave and
// an arithmetic burst-splitting reference model.
module tb_tensor_rd_burst_gen;
  import tensor_rd_burst_gen_pkg::*;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic [2:0]  cmd_valid, arready, rvalid, rready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic [3:0]  cmd_id;
  logic        rlast;
  logic [1:0]  rresp;
  logic [2:0]  cmd_ready, arvalid, busy, done, err;
  logic [31:0] araddr  [3];
  logic [7:0]  arlen   [3];
  logic [2:0]  arsize  [3];
  logic [1:0]  arburst [3];
  logic [3:0]  arid    [3];
  state_t      dbg_state [3];

  // Per-instance configuration: 0 default, 1 narrow bus / short bursts, 2 two in flight.
  int bytes_of [3] = '{32, 4, 32};
  int mb_of    [3] = '{256, 16, 256};
  int max_out  [3] = '{4, 4, 2};
  int size_of  [3] = '{5, 2, 5};

  tensor_rd_burst_gen u_dut0 (
    .aclk(aclk), .areset(areset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .cmd_id(cmd_id),
    .m_axi_araddr(araddr[0]), .m_axi_arlen(arlen[0]), .m_axi_arsize(arsize[0]),
    .m_axi_arburst(arburst[0]), .m_axi_arid(arid[0]), .m_axi_arvalid(arvalid[0]),
    .m_axi_arready(arready[0]), .m_axi_rvalid(rvalid[0]), .m_axi_rready(rready[0]),
    .m_axi_rlast(rlast), .m_axi_rresp(rresp), .busy(busy[0]), .done(done[0]),
    .err(err[0]), .dbg_state(dbg_state[0]));

  tensor_rd_burst_gen #(.DATA_WIDTH(32), .MAX_BURST(16)) u_dut1 (
    .aclk(aclk), .areset(areset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .cmd_id(cmd_id),
    .m_axi_araddr(araddr[1]), .m_axi_arlen(arlen[1]), .m_axi_arsize(arsize[1]),
    .m_axi_arburst(arburst[1]), .m_axi_arid(arid[1]), .m_axi_arvalid(arvalid[1]),
    .m_axi_arready(arready[1]), .m_axi_rvalid(rvalid[1]), .m_axi_rready(rready[1]),
    .m_axi_rlast(rlast), .m_axi_rresp(rresp), .busy(busy[1]), .done(done[1]),
    .err(err[1]), .dbg_state(dbg_state[1]));

  tensor_rd_burst_gen #(.MAX_OUTSTANDING(2)) u_dut2 (
    .aclk(aclk), .areset(areset), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .cmd_id(cmd_id),
    .m_axi_araddr(araddr[2]), .m_axi_arlen(arlen[2]), .m_axi_arsize(arsize[2]),
    .m_axi_arburst(arburst[2]), .m_axi_arid(arid[2]), .m_axi_arvalid(arvalid[2]),
    .m_axi_arready(arready[2]), .m_axi_rvalid(rvalid[2]), .m_axi_rready(rready[2]),
    .m_axi_rlast(rlast), .m_axi_rresp(rresp), .busy(busy[2]), .done(done[2]),
    .err(err[2]), .dbg_state(dbg_state[2]));

  int checks = 0;
  int failures = 0;

  // Scoreboard: expected and observed bursts as {araddr, arlen}.
  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];
  int pend_q[$];
  int cur, ar_pct, r_pct, rdy_pct, err_idx;
  logic [3:0] cur_id;
  int model_out, beats_rx, beat_idx, done_cnt, arvalid_seen;
  int stab_viol, ovr_viol, id_viol, busy_gap;
  logic ar_hold;
  logic [31:0] hold_addr;
  logic [7:0] hold_len;

  task automatic clear_model();
    obs_q.delete(); pend_q.delete(); exp_q.delete();
    model_out = 0; beats_rx = 0; beat_idx = 0; done_cnt = 0; arvalid_seen = 0;
    stab_viol = 0; ovr_viol = 0; id_viol = 0; busy_gap = 0; ar_hold = 1'b0;
    err_idx = -1;
  endtask

  // Reference: greedy split by remaining count, burst cap and 4 KB page end.
  task automatic build_exp(input logic [31:0] addr, input int beats, input int inst);
    logic [31:0] a;
    int rem, len, to4k;
    exp_q.delete();
    a = addr & ~(32'(bytes_of[inst]) - 32'd1);
    rem = beats;
    while (rem > 0) begin
      to4k = (4096 - int'(a[11:0])) / bytes_of[inst];
      len = rem;
      if (len > mb_of[inst]) len = mb_of[inst];
      if (len > to4k) len = to4k;
      exp_q.push_back({a, 8'(len - 1)});
      a = a + 32'(len * bytes_of[inst]);
      rem -= len;
    end
  endtask

  // One clock of the AXI slave: observe after the edge, then drive the next cycle.
  task automatic bus_cycle();
    @(posedge aclk);
    #1;
    if (arvalid[cur]) begin
      arvalid_seen++;
      if (ar_hold && (araddr[cur] !== hold_addr || arlen[cur] !== hold_len)) stab_viol++;
      if (model_out >= max_out[cur]) ovr_viol++;
      if (arid[cur] !== cur_id) id_viol++;
    end
    if (done[cur]) done_cnt++;
    if (!done[cur] && !cmd_ready[cur] && !busy[cur]) busy_gap++;
    arready = '0; rvalid = '0; rready = '0; rlast = 1'b0; rresp = 2'b00;
    if (pend_q.size() > 0 && $urandom_range(99) < r_pct) begin
      rvalid[cur] = 1'b1;
      rlast = (pend_q[0] == 1);
      rresp = (beat_idx == err_idx) ? 2'b10 : 2'b00;
      if ($urandom_range(99) < rdy_pct) begin
        rready[cur] = 1'b1;
        beat_idx++; beats_rx++;
        pend_q[0] = pend_q[0] - 1;
        if (pend_q[0] == 0) begin
          void'(pend_q.pop_front());
          model_out--;
        end
      end
    end
    arready[cur] = ($urandom_range(99) < ar_pct);
    ar_hold = arvalid[cur] && !arready[cur];
    hold_addr = araddr[cur];
    hold_len = arlen[cur];
    if (arvalid[cur] && arready[cur]) begin
      obs_q.push_back({araddr[cur], arlen[cur]});
      pend_q.push_back(int'(arlen[cur]) + 1);
      model_out++;
    end
  endtask

  task automatic start_cmd(input logic [31:0] addr, input logic [15:0] beats, input logic [3:0] id);
    cmd_addr = addr; cmd_beats = beats; cmd_id = id;
    cmd_valid[cur] = 1'b1;
    bus_cycle();
    cmd_valid[cur] = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cmd_ready[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0 || err[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_flags[%0d]: ready=%b busy=%b done=%b err=%b want 1 0 0 0",
                 i, cmd_ready[i], busy[i], done[i], err[i]);
      end
      checks++;
      if (arvalid[i] !== 1'b0 || araddr[i] !== 32'h0 || arlen[i] !== 8'h0 || arid[i] !== 4'h0) begin
        failures++;
        $display("FAIL reset_ar[%0d]: valid=%b addr=%h len=%h id=%h want all 0",
                 i, arvalid[i], araddr[i], arlen[i], arid[i]);
      end
      checks++;
      if (arsize[i] !== 3'(size_of[i]) || arburst[i] !== 2'b01 || dbg_state[i] !== ST_IDLE) begin
        failures++;
        $display("FAIL reset_const[%0d]: arsize=%0d arburst=%b state=%0d want %0d 01 IDLE",
                 i, arsize[i], arburst[i], dbg_state[i], size_of[i]);
      end
    end
  endtask

  task automatic test_split(input string name, input int inst, input logic [31:0] addr,
                            input int beats, input int ar_p, input int r_p, input int e_idx);
    int cyc;
    logic exp_err;
    logic [39:0] e, o;
    cur = inst;
    clear_model();
    ar_pct = ar_p; r_pct = r_p; rdy_pct = 80; err_idx = e_idx;
    cur_id = 4'($urandom_range(15));
    exp_err = (e_idx >= 0 && e_idx < beats);
    build_exp(addr, beats, inst);
    checks++;
    if (cmd_ready[cur] !== 1'b1) begin
      failures++;
      $display("FAIL %s idle_ready: got %b want 1", name, cmd_ready[cur]);
    end
    start_cmd(addr, 16'(beats), cur_id);
    checks++;
    if (err[cur] !== 1'b0 || busy[cur] !== 1'b1) begin
      failures++;
      $display("FAIL %s accept: err=%b busy=%b want 0 1", name, err[cur], busy[cur]);
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      bus_cycle();
      cyc++;
    end
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL %s timeout: no done after %0d cycles", name, cyc);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s burst_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      e = exp_q[i];
      o = obs_q[i];
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s burst%0d: got addr=%h len=%0d want addr=%h len=%0d",
                 name, i, o[39:8], o[7:0], e[39:8], e[7:0]);
      end
    end
    checks++;
    if (beats_rx != beats || pend_q.size() != 0) begin
      failures++;
      $display("FAIL %s done_early: beats returned %0d of %0d at done", name, beats_rx, beats);
    end
    checks++;
    if (err[cur] !== exp_err) begin
      failures++;
      $display("FAIL %s err_at_done: got %b want %b", name, err[cur], exp_err);
    end
    checks++;
    if (stab_viol != 0 || ovr_viol != 0 || id_viol != 0 || busy_gap != 0) begin
      failures++;
      $display("FAIL %s protocol: unstable=%0d over_limit=%0d bad_id=%0d busy_gap=%0d want 0",
               name, stab_viol, ovr_viol, id_viol, busy_gap);
    end
    bus_cycle();
    checks++;
    if (done[cur] !== 1'b0 || cmd_ready[cur] !== 1'b1 || busy[cur] !== 1'b0 || err[cur] !== exp_err) begin
      failures++;
      $display("FAIL %s after_done: done=%b ready=%b busy=%b err=%b want 0 1 0 %b",
               name, done[cur], cmd_ready[cur], busy[cur], err[cur], exp_err);
    end
  endtask

  task automatic test_zero_beats();
    cur = 0;
    clear_model();
    ar_pct = 100; r_pct = 100; rdy_pct = 100;
    cur_id = 4'h3;
    start_cmd(32'h0000_1234, 16'd0, cur_id);
    checks++;
    if (done[cur] !== 1'b1 || busy[cur] !== 1'b0 || dbg_state[cur] !== ST_DONE || err[cur] !== 1'b0) begin
      failures++;
      $display("FAIL zero_done: done=%b busy=%b state=%0d err=%b want 1 0 DONE 0",
               done[cur], busy[cur], dbg_state[cur], err[cur]);
    end
    bus_cycle();
    bus_cycle();
    checks++;
    if (done[cur] !== 1'b0 || cmd_ready[cur] !== 1'b1 || arvalid_seen != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL zero_after: done=%b ready=%b arvalid_cycles=%0d done_cycles=%0d want 0 1 0 1",
               done[cur], cmd_ready[cur], arvalid_seen, done_cnt);
    end
  endtask

  task automatic test_outstanding();
    int cyc;
    logic [39:0] e, o;
    cur = 2;
    clear_model();
    cur_id = 4'hA;
    build_exp(32'h0, 512, 2);
    ar_pct = 100; r_pct = 0; rdy_pct = 100;
    start_cmd(32'h0, 16'd512, cur_id);
    repeat (20) bus_cycle();
    checks++;
    if (obs_q.size() != 2 || arvalid[cur] !== 1'b0) begin
      failures++;
      $display("FAIL out_limit: ar_handshakes=%0d arvalid=%b want 2 0", obs_q.size(), arvalid[cur]);
    end
    ar_pct = 0; r_pct = 100;
    cyc = 0;
    while (pend_q.size() > 1 && cyc < 1000) begin bus_cycle(); cyc++; end
    cyc = 0;
    while (!arvalid[cur] && cyc < 4) begin bus_cycle(); cyc++; end
    checks++;
    if (arvalid[cur] !== 1'b1) begin
      failures++;
      $display("FAIL out_reissue: arvalid=%b after first rlast want 1", arvalid[cur]);
    end
    cyc = 0;
    while (!(pend_q.size() == 1 && pend_q[0] == 1) && cyc < 1000) begin bus_cycle(); cyc++; end
    ar_pct = 100;
    bus_cycle();
    ar_pct = 0; r_pct = 0;
    checks++;
    if (obs_q.size() != 3 || pend_q.size() != 1) begin
      failures++;
      $display("FAIL out_same_cycle_setup: handshakes=%0d pending=%0d want 3 1", obs_q.size(), pend_q.size());
    end
    cyc = 0;
    while (!arvalid[cur] && cyc < 4) begin bus_cycle(); cyc++; end
    checks++;
    if (arvalid[cur] !== 1'b1) begin
      failures++;
      $display("FAIL out_same_cycle: arvalid=%b with one burst in flight want 1", arvalid[cur]);
    end
    ar_pct = 70; r_pct = 70; rdy_pct = 80;
    cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin bus_cycle(); cyc++; end
    checks++;
    if (done_cnt == 0 || beats_rx != 512 || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL out_finish: done=%0d beats=%0d bursts=%0d want 1 512 %0d",
               done_cnt, beats_rx, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      e = exp_q[i];
      o = obs_q[i];
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL out_burst%0d: got %h want %h", i, o, e);
      end
    end
    checks++;
    if (ovr_viol != 0 || stab_viol != 0) begin
      failures++;
      $display("FAIL out_protocol: over_limit=%0d unstable=%0d want 0 0", ovr_viol, stab_viol);
    end
    bus_cycle();
  endtask

  task automatic test_stall_and_reset();
    logic [39:0] e;
    cur = 0;
    clear_model();
    cur_id = 4'h5;
    build_exp(32'h0000_2000, 600, 0);
    e = exp_q[0];
    ar_pct = 0; r_pct = 0; rdy_pct = 100;
    start_cmd(32'h0000_2000, 16'd600, cur_id);
    for (int i = 0; i < 5; i++) begin
      bus_cycle();
      checks++;
      if (arvalid[cur] !== 1'b1 || araddr[cur] !== e[39:8] || arlen[cur] !== e[7:0]) begin
        failures++;
        $display("FAIL stall%0d: valid=%b addr=%h len=%0d want 1 %h %0d",
                 i, arvalid[cur], araddr[cur], arlen[cur], e[39:8], e[7:0]);
      end
    end
    areset = 1'b1;
    bus_cycle();
    areset = 1'b0;
    checks++;
    if (arvalid[cur] !== 1'b0 || busy[cur] !== 1'b0 || cmd_ready[cur] !== 1'b1 || dbg_state[cur] !== ST_IDLE) begin
      failures++;
      $display("FAIL mid_reset: arvalid=%b busy=%b ready=%b state=%0d want 0 0 1 IDLE",
               arvalid[cur], busy[cur], cmd_ready[cur], dbg_state[cur]);
    end
    clear_model();
    bus_cycle();
  endtask

  task automatic test_random();
    int inst, beats, e_idx;
    logic [31:0] addr;
    for (int n = 0; n < 10; n++) begin
      inst = $urandom_range(2);
      addr = $urandom();
      if ($urandom_range(3) == 0) addr = 32'hFFFF_F000 | 32'($urandom_range(4095));
      beats = $urandom_range(1, 400);
      e_idx = ($urandom_range(2) == 0) ? $urandom_range(beats - 1) : -1;
      test_split("random", inst, addr, beats, $urandom_range(30, 100), $urandom_range(30, 100), e_idx);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = '0; arready = '0; rvalid = '0; rready = '0; rlast = 1'b0; rresp = 2'b00;
    cmd_addr = '0; cmd_beats = '0; cmd_id = '0;
    cur = 0; cur_id = '0; ar_pct = 0; r_pct = 0; rdy_pct = 100;
    clear_model();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    test_reset();
    test_split("split_4k", 0, 32'h0000_0F80, 10, 100, 100, -1);
    test_split("split_600", 0, 32'h0000_0000, 600, 60, 70, -1);
    test_split("narrow_40", 1, 32'h0000_0000, 40, 80, 80, -1);
    test_split("unaligned", 0, 32'h0000_0F9F, 10, 50, 50, -1);
    test_split("rresp_err", 0, 32'h0000_0F80, 10, 100, 100, 3);
    test_zero_beats();
    test_outstanding();
    test_stall_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
